d_npc_ras: RTL and testbench

- Parametrised next-generation decode-stage next-PC unit.
- Computes the redirect target for branch, jump-index, jump-register and eret.
- Adds a circular return-address stack (RAS) that records call return addresses and checks every `jr $ra` against the forwarded register value.
- Sits in D stage beside the comparator; `ras_mispredict` feeds the hazard/statistics logic.

---
 rtl/d_npc_ras.sv | 208 ++++++++++++++++++++
 tb/tb_d_npc_ras.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_npc_ras.sv
// ---------------------------------------------------------------------------
// d_npc_ras
//
// Decode-stage next-PC unit with a circular return-address stack (RAS).
//
// The next-PC path picks the redirect target for eret, taken branches,
// jump-index and jump-register instructions. Next to it, the RAS records the
// return address (pc + 8, past the delay slot) of every call. Every `jr $ra`
// is checked against the forwarded register value, and any disagreement is
// flagged on ras_mispredict for the hazard and statistics logic.
//
// Parameters:
//   WIDTH      address/data width
//   RAS_DEPTH  number of RAS entries (power of two, at least 2)
//   PTR_W      pointer width, derived from RAS_DEPTH
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   eret, epc       exception return and its target
//   sel             00 offset, 01 index, 10 register, 11 none
//   pc              D-stage PC
//   br_ctrl         branch condition from the comparator
//   imm16, imm26    sign-extended offset / fully formed jump-index target
//   ra              forwarded rs value
//   is_call/is_ret  jal/jalr and jr $31 in D
//   stall, flush    D stall (RAS holds) / pipeline flush (RAS cleared)
//   npc, is_npc     next PC and "override sequential fetch"
//   ras_top         predicted return address (0 when empty)
//   ras_valid       stack holds at least one entry
//   ras_count       number of valid entries, 0..RAS_DEPTH
//   ras_mispredict  return whose prediction differs from ra
//   ras_overflow    sticky: a call was pushed onto a full stack
//
// Optional feature (macro NPC_STATS_EN):
//   stat_taken      saturating count of unstalled cycles with is_npc
//   stat_mispredict saturating count of unstalled cycles with ras_mispredict
// ---------------------------------------------------------------------------
module d_npc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 8,
    localparam int PTR_W    = $clog2(RAS_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] pc,
    input  logic             br_ctrl,
    input  logic [WIDTH-1:0] imm16,
    input  logic [WIDTH-1:0] imm26,
    input  logic [WIDTH-1:0] ra,
    input  logic             is_call,
    input  logic             is_ret,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] npc,
    output logic             is_npc,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_valid,
    output logic [PTR_W:0]   ras_count,
    output logic             ras_mispredict,
    output logic             ras_overflow
`ifdef NPC_STATS_EN
    ,
    output logic [31:0]      stat_taken,
    output logic [31:0]      stat_mispredict
`endif
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(RAS_DEPTH);

    // RAS storage and bookkeeping
    logic [WIDTH-1:0] memQ [RAS_DEPTH];
    logic [PTR_W-1:0] tpQ, tpD;
    logic [PTR_W:0]   countQ, countD;
    logic             ovfQ, ovfD;

    // Write port into the entry array
    logic             memWe;
    logic [PTR_W-1:0] memWaddr;
    logic [WIDTH-1:0] memWdata;

    logic [PTR_W-1:0] tpTopIdx;
    logic             rasEmpty;
    logic             rasFull;
    logic [WIDTH-1:0] returnAddr;
    logic [WIDTH-1:0] branchTarget;

    // tp is the next free slot, so the newest entry lives one below it.
    // RAS_DEPTH is a power of two, so the pointer arithmetic wraps for free.
    assign tpTopIdx     = tpQ - PTR_W'(1);
    assign rasEmpty     = (countQ == '0);
    assign rasFull      = (countQ == FULL_COUNT);
    assign returnAddr   = pc + WIDTH'(8);
    assign branchTarget = pc + WIDTH'(4) + (imm16 << 2);

    // Next-PC selection in priority order: eret, taken branch, jump-index,
    // jump-register, then fall-through past the delay slot. A not-taken
    // branch still asserts is_npc; its target is then pc + 8.
    always_comb begin
        npc = returnAddr;
        if (eret) begin
            npc = epc;
        end else if (sel == 2'b00 && br_ctrl) begin
            npc = branchTarget;
        end else if (sel == 2'b01) begin
            npc = imm26;
        end else if (sel == 2'b10) begin
            npc = ra;
        end
    end

    assign is_npc = eret | (sel != 2'b11);

    // Prediction outputs read straight from the current stack state.
    assign ras_valid      = !rasEmpty;
    assign ras_top        = rasEmpty ? '0 : memQ[tpTopIdx];
    assign ras_count      = countQ;
    assign ras_overflow   = ovfQ;
    assign ras_mispredict = is_ret & (rasEmpty | (ras_top != ra));

    // Next-state of the stack. A flush empties it without touching the sticky
    // overflow flag; a stall freezes it. A combined call+ret (jalr $31)
    // replaces the top entry in place, unless the stack is empty, in which
    // case it behaves as a plain push. Pushing onto a full stack overwrites
    // the oldest entry, which is exactly the slot tp already points at.
    always_comb begin
        tpD      = tpQ;
        countD   = countQ;
        ovfD     = ovfQ;
        memWe    = 1'b0;
        memWaddr = tpQ;
        memWdata = returnAddr;
        if (flush) begin
            tpD    = '0;
            countD = '0;
        end else if (!stall) begin
            if (is_call && (!is_ret || rasEmpty)) begin
                memWe    = 1'b1;
                memWaddr = tpQ;
                tpD      = tpQ + PTR_W'(1);
                if (rasFull) begin
                    ovfD = 1'b1;
                end else begin
                    countD = countQ + (PTR_W+1)'(1);
                end
            end else if (is_call && is_ret) begin
                memWe    = 1'b1;
                memWaddr = tpTopIdx;
            end else if (is_ret && !rasEmpty) begin
                tpD    = tpTopIdx;
                countD = countQ - (PTR_W+1)'(1);
            end
        end
    end

    // Pointer, count and overflow registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tpQ    <= '0;
            countQ <= '0;
            ovfQ   <= 1'b0;
        end else begin
            tpQ    <= tpD;
            countQ <= countD;
            ovfQ   <= ovfD;
        end
    end

    // Entry array. Contents are left alone on reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (rst_n && memWe) begin
            memQ[memWaddr] <= memWdata;
        end
    end

`ifdef NPC_STATS_EN
    logic [31:0] statTakenQ, statTakenD;
    logic [31:0] statMisQ, statMisD;

    // Saturating event counters; flush does not clear them.
    always_comb begin
        statTakenD = statTakenQ;
        statMisD   = statMisQ;
        if (!stall && is_npc && (statTakenQ != 32'hFFFF_FFFF)) begin
            statTakenD = statTakenQ + 32'd1;
        end
        if (!stall && ras_mispredict && (statMisQ != 32'hFFFF_FFFF)) begin
            statMisD = statMisQ + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            statTakenQ <= '0;
            statMisQ   <= '0;
        end else begin
            statTakenQ <= statTakenD;
            statMisQ   <= statMisD;
        end
    end

    assign stat_taken      = statTakenQ;
    assign stat_mispredict = statMisQ;
`endif

endmodule

// File: tb/tb_d_npc_ras.sv
// ---------------------------------------------------------------------------
// tb_d_npc_ras
//
// Self-checking bench for d_npc_ras with default parameters (WIDTH=32,
// RAS_DEPTH=8). Each stimulus pushes its expected outputs, taken from a small
// behavioural model, onto a queue; they are popped and compared once the
// combinational outputs have settled. Directed scenarios add fixed-value
// checks on top.
// ---------------------------------------------------------------------------
module tb_d_npc_ras;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             eret;
    logic [WIDTH-1:0] epc;
    logic [1:0]       sel;
    logic [WIDTH-1:0] pc;
    logic             br_ctrl;
    logic [WIDTH-1:0] imm16;
    logic [WIDTH-1:0] imm26;
    logic [WIDTH-1:0] ra;
    logic             is_call;
    logic             is_ret;
    logic             stall;
    logic             flush;
    logic [WIDTH-1:0] npc;
    logic             is_npc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_valid;
    logic [PTR_W:0]   ras_count;
    logic             ras_mispredict;
    logic             ras_overflow;
`ifdef NPC_STATS_EN
    logic [31:0]      stat_taken;
    logic [31:0]      stat_mispredict;
`endif

    d_npc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .eret           (eret),
        .epc            (epc),
        .sel            (sel),
        .pc             (pc),
        .br_ctrl        (br_ctrl),
        .imm16          (imm16),
        .imm26          (imm26),
        .ra             (ra),
        .is_call        (is_call),
        .is_ret         (is_ret),
        .stall          (stall),
        .flush          (flush),
        .npc            (npc),
        .is_npc         (is_npc),
        .ras_top        (ras_top),
        .ras_valid      (ras_valid),
        .ras_count      (ras_count),
        .ras_mispredict (ras_mispredict),
        .ras_overflow   (ras_overflow)
`ifdef NPC_STATS_EN
        ,
        .stat_taken     (stat_taken),
        .stat_mispredict(stat_mispredict)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstN;
        logic        eret;
        logic [31:0] epc;
        logic [1:0]  sel;
        logic [31:0] pc;
        logic        br;
        logic [31:0] imm16;
        logic [31:0] imm26;
        logic [31:0] ra;
        logic        call;
        logic        ret;
        logic        stall;
        logic        flush;
    } stim_t;

    typedef struct {
        logic [31:0] npc;
        logic        isNpc;
        logic [31:0] top;
        logic        valid;
        logic [3:0]  count;
        logic        mis;
        logic        ovf;
        logic [31:0] statTaken;
        logic [31:0] statMis;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model of the stack
    logic [31:0] mMem [DEPTH];
    int          mTp;
    int          mCount;
    logic        mOvf;
    logic [31:0] mStatTaken;
    logic [31:0] mStatMis;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic stim_t idleStim(input logic [31:0] pcv);
        stim_t s;
        s.rstN  = 1'b1;
        s.eret  = 1'b0;
        s.epc   = 32'h0;
        s.sel   = 2'b11;
        s.pc    = pcv;
        s.br    = 1'b0;
        s.imm16 = 32'h0;
        s.imm26 = 32'h0;
        s.ra    = 32'h0;
        s.call  = 1'b0;
        s.ret   = 1'b0;
        s.stall = 1'b0;
        s.flush = 1'b0;
        return s;
    endfunction

    function automatic logic [31:0] modelTop();
        return (mCount > 0) ? mMem[(mTp + DEPTH - 1) % DEPTH] : 32'h0;
    endfunction

    function automatic exp_t modelExpect(input stim_t s);
        exp_t e;
        if (s.eret)                    e.npc = s.epc;
        else if (s.sel == 2'b00 && s.br) e.npc = s.pc + 32'd4 + (s.imm16 << 2);
        else if (s.sel == 2'b01)       e.npc = s.imm26;
        else if (s.sel == 2'b10)       e.npc = s.ra;
        else                           e.npc = s.pc + 32'd8;
        e.isNpc     = s.eret | (s.sel != 2'b11);
        e.top       = modelTop();
        e.valid     = (mCount != 0);
        e.count     = 4'(mCount);
        e.mis       = s.ret & ((mCount == 0) | (modelTop() != s.ra));
        e.ovf       = mOvf;
        e.statTaken = mStatTaken;
        e.statMis   = mStatMis;
        return e;
    endfunction

    task automatic modelPush(input logic [31:0] val);
        mMem[mTp] = val;
        mTp = (mTp + 1) % DEPTH;
        if (mCount == DEPTH) mOvf = 1'b1;
        else mCount++;
    endtask

    task automatic modelUpdate(input stim_t s, input exp_t e);
        if (!s.rstN) begin
            mTp = 0; mCount = 0; mOvf = 1'b0;
            mStatTaken = 0; mStatMis = 0;
            return;
        end
        if (!s.stall && e.isNpc && mStatTaken != 32'hFFFF_FFFF) mStatTaken++;
        if (!s.stall && e.mis && mStatMis != 32'hFFFF_FFFF) mStatMis++;
        if (s.flush) begin
            mTp = 0; mCount = 0;
        end else if (!s.stall) begin
            if (s.call && !s.ret) begin
                modelPush(s.pc + 32'd8);
            end else if (s.ret && !s.call) begin
                if (mCount > 0) begin
                    mTp = (mTp + DEPTH - 1) % DEPTH;
                    mCount--;
                end
            end else if (s.call && s.ret) begin
                if (mCount > 0) mMem[(mTp + DEPTH - 1) % DEPTH] = s.pc + 32'd8;
                else modelPush(s.pc + 32'd8);
            end
        end
    endtask

    task automatic driveInputs(input stim_t s);
        rst_n   = s.rstN;
        eret    = s.eret;
        epc     = s.epc;
        sel     = s.sel;
        pc      = s.pc;
        br_ctrl = s.br;
        imm16   = s.imm16;
        imm26   = s.imm26;
        ra      = s.ra;
        is_call = s.call;
        is_ret  = s.ret;
        stall   = s.stall;
        flush   = s.flush;
    endtask

    task automatic checkScoreboard();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected one entry");
            return;
        end
        e = expQ.pop_front();
        checkOutput("npc",       npc,            e.npc);
        checkOutput("is_npc",    is_npc,         e.isNpc);
        checkOutput("ras_top",   ras_top,        e.top);
        checkOutput("ras_valid", ras_valid,      e.valid);
        checkOutput("ras_count", ras_count,      e.count);
        checkOutput("mispred",   ras_mispredict, e.mis);
        checkOutput("overflow",  ras_overflow,   e.ovf);
`ifdef NPC_STATS_EN
        checkOutput("statTaken", stat_taken,      e.statTaken);
        checkOutput("statMis",   stat_mispredict, e.statMis);
`endif
    endtask

    // Drive on the falling edge, compare just after, then advance the model
    // to the state the next rising edge produces.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(negedge clk);
        driveInputs(s);
        e = modelExpect(s);
        expQ.push_back(e);
        #1;
        checkScoreboard();
        modelUpdate(s, e);
    endtask

    // Let the pending edge happen so registered state can be inspected.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        stim_t s;
        s = idleStim(32'h3000);
        s.rstN = 1'b0;
        @(negedge clk);
        driveInputs(s);
        repeat (2) @(posedge clk);
        mTp = 0; mCount = 0; mOvf = 1'b0;
        mStatTaken = 0; mStatMis = 0;
    endtask

    initial begin
        stim_t s;

        doReset();

        // Idle after reset
        s = idleStim(32'h3000);
        applyStimulus(s);
        checkOutput("rstNpc",   npc,          32'h3008);
        checkOutput("rstIsNpc", is_npc,       1'b0);
        checkOutput("rstCount", ras_count,    4'd0);
        checkOutput("rstTop",   ras_top,      32'h0);
        checkOutput("rstOvf",   ras_overflow, 1'b0);

        // Next-PC selection patterns
        s = idleStim(32'h3000);
        s.sel = 2'b00; s.br = 1'b1; s.imm16 = 32'hFFFF_FFFF;
        applyStimulus(s);
        checkOutput("brBack", npc, 32'h3000);

        s = idleStim(32'h3000);
        s.sel = 2'b00; s.br = 1'b1; s.imm16 = 32'h0000_0010;
        applyStimulus(s);
        checkOutput("brFwd", npc, 32'h3044);

        s = idleStim(32'h3000);
        s.sel = 2'b00; s.br = 1'b0; s.imm16 = 32'h0000_0010;
        applyStimulus(s);
        checkOutput("brNotTaken", npc, 32'h3008);

        s = idleStim(32'h3000);
        s.eret = 1'b1; s.epc = 32'h4180; s.sel = 2'b01; s.imm26 = 32'h5000;
        applyStimulus(s);
        checkOutput("eretNpc",   npc,    32'h4180);
        checkOutput("eretIsNpc", is_npc, 1'b1);

        s = idleStim(32'h3000);
        s.sel = 2'b01; s.imm26 = 32'h0040_0000;
        applyStimulus(s);

        s = idleStim(32'h3000);
        s.sel = 2'b10; s.ra = 32'hDEAD_BEE0;
        applyStimulus(s);

        // Single call / matched return / return on empty stack
        s = idleStim(32'h3010);
        s.call = 1'b1; s.sel = 2'b01; s.imm26 = 32'h6000;
        applyStimulus(s);
        settle();
        checkOutput("callTop",   ras_top,   32'h3018);
        checkOutput("callCount", ras_count, 4'd1);

        s = idleStim(32'h6004);
        s.ret = 1'b1; s.sel = 2'b10; s.ra = 32'h3018;
        applyStimulus(s);
        checkOutput("retHit", ras_mispredict, 1'b0);
        settle();
        checkOutput("retCount", ras_count, 4'd0);

        applyStimulus(s);
        checkOutput("retEmptyMis", ras_mispredict, 1'b1);
        settle();
        checkOutput("retEmptyCount", ras_count, 4'd0);

        // Overflow: nine calls into an eight-deep stack
        for (int k = 0; k < 9; k++) begin
            s = idleStim(32'h3000 + 32'(16 * k));
            s.call = 1'b1;
            applyStimulus(s);
        end
        settle();
        checkOutput("ovfCount", ras_count,    4'd8);
        checkOutput("ovfFlag",  ras_overflow, 1'b1);
        checkOutput("ovfTop",   ras_top,      32'h3088);

        for (int j = 0; j < 8; j++) begin
            s = idleStim(32'h7000);
            s.ret = 1'b1; s.sel = 2'b10; s.ra = 32'h3088 - 32'(16 * j);
            applyStimulus(s);
            checkOutput("popTop", ras_top, 32'h3088 - 32'(16 * j));
        end
        settle();
        checkOutput("popEmpty", ras_count, 4'd0);

        // Stall and flush
        s = idleStim(32'h3200);
        s.call = 1'b1;
        applyStimulus(s);
        s.pc = 32'h3300; s.stall = 1'b1;
        applyStimulus(s);
        settle();
        checkOutput("stallCount", ras_count, 4'd1);
        checkOutput("stallTop",   ras_top,   32'h3208);
        s.stall = 1'b0; s.flush = 1'b1;
        applyStimulus(s);
        settle();
        checkOutput("flushCount", ras_count,    4'd0);
        checkOutput("flushOvf",   ras_overflow, 1'b1);

        // Two calls then call+ret replaces the top in place
        s = idleStim(32'h3000);
        s.call = 1'b1;
        applyStimulus(s);
        s.pc = 32'h3010;
        applyStimulus(s);
        s.pc = 32'h3100; s.ret = 1'b1; s.ra = 32'h3018;
        applyStimulus(s);
        settle();
        checkOutput("swapTop",   ras_top,   32'h3108);
        checkOutput("swapCount", ras_count, 4'd2);

        // Reset with five entries present
        for (int k = 0; k < 3; k++) begin
            s = idleStim(32'h3400 + 32'(16 * k));
            s.call = 1'b1;
            applyStimulus(s);
        end
        s = idleStim(32'h3500);
        applyStimulus(s);
        checkOutput("preRstCount", ras_count, 4'd5);
        s.rstN = 1'b0;
        applyStimulus(s);
        settle();
        checkOutput("midRstCount", ras_count,    4'd0);
        checkOutput("midRstOvf",   ras_overflow, 1'b0);
`ifdef NPC_STATS_EN
        checkOutput("midRstTaken", stat_taken,      32'd0);
        checkOutput("midRstMis",   stat_mispredict, 32'd0);
`endif

        // Random mix checked against the model
        for (int n = 0; n < 60; n++) begin
            s = idleStim(32'h3000 + 32'($urandom_range(0, 255) * 4));
            s.eret  = ($urandom_range(0, 9) == 0);
            s.epc   = $urandom;
            s.sel   = 2'($urandom_range(0, 3));
            s.br    = 1'($urandom_range(0, 1));
            s.imm16 = 32'($signed(16'($urandom)));
            s.imm26 = $urandom;
            s.call  = ($urandom_range(0, 2) == 0);
            s.ret   = ($urandom_range(0, 2) == 0);
            s.ra    = ($urandom_range(0, 1) == 1) ? modelTop() : $urandom;
            s.stall = ($urandom_range(0, 5) == 0);
            s.flush = ($urandom_range(0, 15) == 0);
            applyStimulus(s);
        end
        s = idleStim(32'h3000);
        applyStimulus(s);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
